// File: rtl/mem_seq.sv
// -----------------------------------------------------------------------------
// mem_seq -- memory access sequencer for a simple CPU datapath.
//
// Takes one access request at a time from the control unit and walks it
// through address load, a memory wait phase, an optional data latch and a
// completion pulse. A wait phase that outlasts WAIT_MAX cycles is aborted and
// reported through timeout_err.
//
// Parameters
//   WAIT_MAX       maximum cycles spent in a wait state before timeout (1..255)
//
// Ports
//   i_clock        system clock, all state changes on the rising edge
//   i_reset        asynchronous active-high reset
//   i_req          access request, sampled only in IDLE
//   i_we           access direction (1 = write), sampled together with i_req
//   i_mem_ready    memory completion flag, sampled only in the wait states
//   o_busy         high in every state except IDLE
//   o_mari         MAR load strobe
//   o_mem_rd       memory read strobe
//   o_mem_wr       memory write strobe
//   o_mdri         MDR load-from-memory strobe
//   o_mdro         MDR drive-to-memory enable
//   o_done         one-cycle transaction-complete pulse
//   o_timeout_err  one-cycle pulse with o_done marking an aborted access
// -----------------------------------------------------------------------------
module mem_seq #(
  parameter int WAIT_MAX = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_req,
  input  logic i_we,
  input  logic i_mem_ready,
  output logic o_busy,
  output logic o_mari,
  output logic o_mem_rd,
  output logic o_mem_wr,
  output logic o_mdri,
  output logic o_mdro,
  output logic o_done,
  output logic o_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ_WAIT,
    S_READ_LATCH,
    S_WRITE_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // Last counter value allowed in a wait state; the counter reads 0 on the
  // first wait cycle, so reaching this value means WAIT_MAX cycles were spent.
  localparam logic [7:0] C_WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_we_q;
  logic [7:0]  r_wait_cnt;
  logic        w_wait_expired;
  logic        w_in_wait;

  assign w_wait_expired = (r_wait_cnt == C_WAIT_LAST);
  assign w_in_wait      = (r_state == S_READ_WAIT) || (r_state == S_WRITE_WAIT);

  // Next-state decode. mem_ready is tested before the timeout so that a
  // completion arriving on the last allowed wait cycle still succeeds.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:       if (i_req) w_state_next = S_ADDR;
      S_ADDR:       w_state_next = r_we_q ? S_WRITE_WAIT : S_READ_WAIT;
      S_READ_WAIT: begin
        if (i_mem_ready)         w_state_next = S_READ_LATCH;
        else if (w_wait_expired) w_state_next = S_ERR;
      end
      S_READ_LATCH: w_state_next = S_DONE;
      S_WRITE_WAIT: begin
        if (i_mem_ready)         w_state_next = S_DONE;
        else if (w_wait_expired) w_state_next = S_ERR;
      end
      S_DONE:       w_state_next = S_IDLE;
      S_ERR:        w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  // State, captured direction, wait counter and registered Moore outputs.
  // Outputs are decoded from the next state so that, once registered, they
  // line up exactly with the state they belong to.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_we_q        <= 1'b0;
      r_wait_cnt    <= 8'd0;
      o_busy        <= 1'b0;
      o_mari        <= 1'b0;
      o_mem_rd      <= 1'b0;
      o_mem_wr      <= 1'b0;
      o_mdri        <= 1'b0;
      o_mdro        <= 1'b0;
      o_done        <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // Direction is latched only at acceptance; later changes on i_we are
      // ignored until the next access.
      if (r_state == S_IDLE && i_req)
        r_we_q <= i_we;

      // Wait states are only entered from ADDR, so clearing there is the
      // same as clearing on entry.
      if (r_state == S_ADDR)
        r_wait_cnt <= 8'd0;
      else if (w_in_wait)
        r_wait_cnt <= r_wait_cnt + 8'd1;

      o_busy        <= (w_state_next != S_IDLE);
      o_mari        <= (w_state_next == S_ADDR);
      o_mem_rd      <= (w_state_next == S_READ_WAIT);
      o_mem_wr      <= (w_state_next == S_WRITE_WAIT);
      o_mdro        <= (w_state_next == S_WRITE_WAIT);
      o_mdri        <= (w_state_next == S_READ_LATCH);
      o_done        <= (w_state_next == S_DONE) || (w_state_next == S_ERR);
      o_timeout_err <= (w_state_next == S_ERR);
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// -----------------------------------------------------------------------------
// tb_mem_seq -- self-checking bench for mem_seq.
//
// Each access is described by its direction and by the wait-cycle index on
// which memory reports ready. From that description a transaction-level model
// builds the expected output vector for every cycle of the access, which is
// then compared cycle by cycle against the DUT. Inputs the DUT must ignore
// (req/we while busy, mem_ready outside wait states) are randomised.
// -----------------------------------------------------------------------------
module tb_mem_seq;

  localparam int WM = 4;

  // Output vector bit positions
  localparam logic [7:0] B_BUSY = 8'h80;
  localparam logic [7:0] B_MARI = 8'h40;
  localparam logic [7:0] B_RD   = 8'h20;
  localparam logic [7:0] B_WR   = 8'h10;
  localparam logic [7:0] B_MDRI = 8'h08;
  localparam logic [7:0] B_MDRO = 8'h04;
  localparam logic [7:0] B_DONE = 8'h02;
  localparam logic [7:0] B_TERR = 8'h01;

  logic clk;
  logic rst;
  logic req;
  logic we;
  logic mem_ready;
  logic busy, mari, mem_rd, mem_wr, mdri, mdro, done, timeout_err;
  logic [7:0] vec;

  int n_checks;
  int n_errors;
  int n_txn;
  logic [7:0] exp_q[$];

  mem_seq #(.WAIT_MAX(WM)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_req         (req),
    .i_we          (we),
    .i_mem_ready   (mem_ready),
    .o_busy        (busy),
    .o_mari        (mari),
    .o_mem_rd      (mem_rd),
    .o_mem_wr      (mem_wr),
    .o_mdri        (mdri),
    .o_mdro        (mdro),
    .o_done        (done),
    .o_timeout_err (timeout_err)
  );

  assign vec = {busy, mari, mem_rd, mem_wr, mdri, mdro, done, timeout_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one access. rdy_idx is the wait cycle
  // (0-based) on which mem_ready is first high; an index of WM or more means
  // memory never answers within the allowed window.
  task automatic build_exp(input bit w, input int rdy_idx);
    int  n_wait;
    bit  to;
    exp_q.delete();
    to     = (rdy_idx >= WM);
    n_wait = to ? WM : rdy_idx + 1;
    exp_q.push_back(B_BUSY | B_MARI);
    repeat (n_wait) exp_q.push_back(w ? (B_BUSY | B_WR | B_MDRO) : (B_BUSY | B_RD));
    if (!w && !to) exp_q.push_back(B_BUSY | B_MDRI);
    exp_q.push_back(to ? (B_BUSY | B_DONE | B_TERR) : (B_BUSY | B_DONE));
  endtask

  // Entered and left just after a rising edge with the DUT in IDLE.
  task automatic run_txn(input bit w, input int rdy_idx, input int gap, input bit hold_req);
    int widx;
    repeat (gap) begin
      req = 1'b0; we = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      check_val("idle_gap", 32'(vec), 32'h0);
      @(posedge clk); #1;
    end
    req = 1'b1; we = w; mem_ready = 1'($urandom);
    @(negedge clk);
    check_val("idle_accept", 32'(vec), 32'h0);
    @(posedge clk); #1;
    build_exp(w, rdy_idx);
    $display("txn %0d: we=%0b rdy_idx=%0d cycles=%0d", n_txn, w, rdy_idx, exp_q.size());
    n_txn++;
    foreach (exp_q[c]) begin
      req = hold_req ? 1'b1 : 1'($urandom);
      we  = 1'($urandom);
      // Wait cycles occupy expected-trace entries 1..n_wait.
      widx = c - 1;
      if (c >= 1 && (exp_q[c] & (B_RD | B_WR)) != 8'h0)
        mem_ready = (widx >= rdy_idx);
      else
        mem_ready = 1'($urandom);
      @(negedge clk);
      check_val(w ? "wr_cycle" : "rd_cycle", 32'(vec), 32'(exp_q[c]));
      check_val("strobe_excl",
                32'(($countones({mari, mem_rd, mem_wr, mdri}) <= 1) && (!mdro || mem_wr)), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_txn    = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; mem_ready = 1'b0;
    #1;
    check_val("reset_async_outputs", 32'(vec), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset_idle", 32'(vec), 32'h0);
    @(posedge clk); #1;

    // Directed cases
    run_txn(1'b0, 0, 0, 1'b0);        // read, ready already high: done at cycle 4
    run_txn(1'b1, 0, 1, 1'b0);        // write, ready already high: done at cycle 3
    run_txn(1'b1, 2, 1, 1'b0);        // write, ready on 3rd wait cycle
    run_txn(1'b0, WM + 3, 1, 1'b0);   // read timeout
    run_txn(1'b0, WM - 1, 1, 1'b0);   // read, ready on last allowed cycle
    run_txn(1'b1, WM - 1, 1, 1'b0);   // write tie
    run_txn(1'b1, WM, 1, 1'b0);       // write timeout

    // Reset in the middle of READ_WAIT
    req = 1'b1; we = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;               // ADDR
    req = 1'b0;
    @(posedge clk); #1;               // READ_WAIT
    @(negedge clk);
    check_val("pre_reset_rd", 32'(vec), 32'(B_BUSY | B_RD));
    #1 rst = 1'b1;
    #1 check_val("mid_reset_outputs", 32'(vec), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      req = 1'b0; mem_ready = 1'($urandom);
      @(negedge clk);
      check_val("post_reset_quiet", 32'(vec), 32'h0);
      @(posedge clk); #1;
    end
    run_txn(1'b0, 0, 0, 1'b0);        // clean read with nominal timing

    // Back-to-back with req held high and alternating direction
    for (int i = 0; i < 8; i++) run_txn(1'(i % 2), 0, 0, 1'b1);

    // Randomised accesses
    for (int i = 0; i < 150; i++)
      run_txn(1'($urandom), int'($urandom_range(0, WM + 2)),
              int'($urandom_range(0, 2)), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
